// File: rtl/can_mc_pkg.sv
// Shared definitions for the MCU register write channel: arbiter states and
// the writable register map used by both the arbiter and the write decoder.
package can_mc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2,
        GAP   = 2'd3
    } wr_arb_state_t;

    // Writable windows; 0x00 is the implicit lower bound of the first window
    localparam logic [5:0] WR_ADDR_A_HI = 6'h03;
    localparam logic [5:0] WR_ADDR_B    = 6'h05;
    localparam logic [5:0] WR_ADDR_C_LO = 6'h08;
    localparam logic [5:0] WR_ADDR_C_HI = 6'h11;
    localparam logic [5:0] WR_ADDR_D_LO = 6'h18;
    localparam logic [5:0] WR_ADDR_D_HI = 6'h20;

    function automatic logic is_wr_addr_mapped(input logic [5:0] addr);
        return (addr <= WR_ADDR_A_HI)
            || (addr == WR_ADDR_B)
            || ((addr >= WR_ADDR_C_LO) && (addr <= WR_ADDR_C_HI))
            || ((addr >= WR_ADDR_D_LO) && (addr <= WR_ADDR_D_HI));
    endfunction

endpackage

// File: rtl/can_mc_wr_arbiter_if.sv
// Request/response and write-channel signals between the two requesters,
// the arbiter and the register decoder.
interface can_mc_wr_arbiter_if;

    logic [1:0]  i_req_valid;
    logic [5:0]  i_req0_addr;
    logic [31:0] i_req0_data;
    logic [5:0]  i_req1_addr;
    logic [31:0] i_req1_data;
    logic [1:0]  o_req_ready;
    logic [1:0]  o_rsp_valid;
    logic        o_rsp_err;
    logic        o_wr_en;
    logic [5:0]  o_addr;
    logic [31:0] o_bus_data;
    logic        o_busy;

    modport slave (
        input  i_req_valid, i_req0_addr, i_req0_data, i_req1_addr, i_req1_data,
        output o_req_ready, o_rsp_valid, o_rsp_err, o_wr_en, o_addr, o_bus_data, o_busy
    );

    modport master (
        output i_req_valid, i_req0_addr, i_req0_data, i_req1_addr, i_req1_data,
        input  o_req_ready, o_rsp_valid, o_rsp_err, o_wr_en, o_addr, o_bus_data, o_busy
    );

endinterface

// File: rtl/can_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins outright, a tie goes to
// whichever requester was not granted last.
module can_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    always_comb begin
        grant_valid = |req;
        grant_idx   = 1'b0;
        case (req)
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_grant;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/can_mc_wr_arbiter.sv
// Shares the register write channel between the host MCU bus (requester 0)
// and the power-up config loader (requester 1).
module can_mc_wr_arbiter
    import can_mc_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 0
) (
    input logic                i_clk,
    input logic                i_reset,
    can_mc_wr_arbiter_if.slave bus
);

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

    wr_arb_state_t state, state_nxt;
    logic          last_grant, last_grant_nxt;
    logic [3:0]    gap_cnt, gap_cnt_nxt;
    logic          owner, owner_nxt;
    logic          err, err_nxt;
    logic [5:0]    addr_q, addr_nxt;
    logic [31:0]   data_q, data_nxt;
    logic          wr_en_q, wr_en_nxt;
    logic [1:0]    rsp_valid_q, rsp_valid_nxt;
    logic          rsp_err_q, rsp_err_nxt;

    logic          grant_valid, grant_idx, accept, sel_mapped;
    logic [5:0]    sel_addr;
    logic [31:0]   sel_data;

    can_rr_arb2 u_arb (
        .req         (bus.i_req_valid),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        sel_addr   = grant_idx ? bus.i_req1_addr : bus.i_req0_addr;
        sel_data   = grant_idx ? bus.i_req1_data : bus.i_req0_data;
        sel_mapped = is_wr_addr_mapped(sel_addr);
        accept     = (state == IDLE) && grant_valid;
        bus.o_req_ready = 2'b00;
        if (accept) bus.o_req_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            gap_cnt     <= '0;
            owner       <= 1'b0;
            err         <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            wr_en_q     <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            last_grant  <= last_grant_nxt;
            gap_cnt     <= gap_cnt_nxt;
            owner       <= owner_nxt;
            err         <= err_nxt;
            addr_q      <= addr_nxt;
            data_q      <= data_nxt;
            wr_en_q     <= wr_en_nxt;
            rsp_valid_q <= rsp_valid_nxt;
            rsp_err_q   <= rsp_err_nxt;
        end
    end

    // Pulse outputs are computed one cycle early so they come straight from flops
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        gap_cnt_nxt    = gap_cnt;
        owner_nxt      = owner;
        err_nxt        = err;
        addr_nxt       = addr_q;
        data_nxt       = data_q;
        wr_en_nxt      = 1'b0;
        rsp_valid_nxt  = 2'b00;
        rsp_err_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    last_grant_nxt = grant_idx;
                    owner_nxt      = grant_idx;
                    err_nxt        = ~sel_mapped;
                    if (sel_mapped) begin
                        state_nxt = WRITE;
                        addr_nxt  = sel_addr;
                        data_nxt  = sel_data;
                        wr_en_nxt = 1'b1;
                    end else begin
                        state_nxt                = RESP;
                        rsp_valid_nxt[grant_idx] = 1'b1;
                        rsp_err_nxt              = 1'b1;
                    end
                end
            end
            WRITE: begin
                state_nxt            = RESP;
                rsp_valid_nxt[owner] = 1'b1;
                rsp_err_nxt          = err;
            end
            RESP: begin
                if (GAP_LOAD != 4'd0) begin
                    state_nxt   = GAP;
                    gap_cnt_nxt = GAP_LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GAP: begin
                gap_cnt_nxt = gap_cnt - 4'd1;
                if (gap_cnt == 4'd1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A write pulse already in flight is suppressed the moment reset is seen
    assign bus.o_wr_en     = wr_en_q & ~i_reset;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_err   = rsp_err_q;
    assign bus.o_addr      = addr_q;
    assign bus.o_bus_data  = data_q;
    assign bus.o_busy      = (state != IDLE);

endmodule

// File: tb/tb_can_mc_wr_arbiter.sv
// Bench for can_mc_wr_arbiter: two instances (gap 0 and gap 3) share one set of
// requester inputs and are checked every cycle against a timeline model.
module tb_can_mc_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [5:0]  a0 = '0, a1 = '0;
    logic [31:0] d0 = '0, d1 = '0;

    always #5 clk = ~clk;

    can_mc_wr_arbiter_if if0 ();
    can_mc_wr_arbiter_if if3 ();

    assign if0.i_req_valid = req_valid;
    assign if0.i_req0_addr = a0;
    assign if0.i_req0_data = d0;
    assign if0.i_req1_addr = a1;
    assign if0.i_req1_data = d1;
    assign if3.i_req_valid = req_valid;
    assign if3.i_req0_addr = a0;
    assign if3.i_req0_data = d0;
    assign if3.i_req1_addr = a1;
    assign if3.i_req1_data = d1;

    can_mc_wr_arbiter #(.GAP_CYCLES(0)) dut0 (.i_clk(clk), .i_reset(rst), .bus(if0.slave));
    can_mc_wr_arbiter #(.GAP_CYCLES(3)) dut3 (.i_clk(clk), .i_reset(rst), .bus(if3.slave));

    logic [1:0]  o_ready [2];
    logic [1:0]  o_rsp   [2];
    logic        o_err   [2];
    logic        o_wr    [2];
    logic        o_busy  [2];
    logic [5:0]  o_addr  [2];
    logic [31:0] o_data  [2];

    assign o_ready[0] = if0.o_req_ready;  assign o_ready[1] = if3.o_req_ready;
    assign o_rsp[0]   = if0.o_rsp_valid;  assign o_rsp[1]   = if3.o_rsp_valid;
    assign o_err[0]   = if0.o_rsp_err;    assign o_err[1]   = if3.o_rsp_err;
    assign o_wr[0]    = if0.o_wr_en;      assign o_wr[1]    = if3.o_wr_en;
    assign o_busy[0]  = if0.o_busy;       assign o_busy[1]  = if3.o_busy;
    assign o_addr[0]  = if0.o_addr;       assign o_addr[1]  = if3.o_addr;
    assign o_data[0]  = if0.o_bus_data;   assign o_data[1]  = if3.o_bus_data;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic bit mapped(input logic [5:0] a);
        return a inside {[6'h00:6'h03], 6'h05, [6'h08:6'h11], [6'h18:6'h20]};
    endfunction

    // Timeline model: an accepted request books its write and response cycles
    // and the first cycle at which the arbiter is free again.
    int          gap_of  [2] = '{0, 3};
    int          free_at [2] = '{0, 0};
    int          wr_cyc  [2] = '{-1, -1};
    int          rsp_cyc [2] = '{-1, -1};
    bit          m_last  [2] = '{1'b1, 1'b1};
    bit          rsp_idx [2] = '{1'b0, 1'b0};
    bit          rsp_err [2] = '{1'b0, 1'b0};
    logic [5:0]  m_addr  [2] = '{6'h0, 6'h0};
    logic [5:0]  p_addr  [2] = '{6'h0, 6'h0};
    logic [31:0] m_data  [2] = '{32'h0, 32'h0};
    logic [31:0] p_data  [2] = '{32'h0, 32'h0};

    always @(negedge clk) begin
        bit         idle, has_g, g, e_wr, e_err;
        logic [1:0] e_ready, e_rsp;
        logic [5:0] a;
        logic [31:0] d;
        if (cyc >= 1) begin
            for (int k = 0; k < 2; k++) begin
                if (cyc == wr_cyc[k]) begin
                    m_addr[k] = p_addr[k];
                    m_data[k] = p_data[k];
                end
                idle  = (cyc >= free_at[k]);
                has_g = (req_valid != 2'b00);
                if (req_valid == 2'b11) g = !m_last[k];
                else                    g = (req_valid == 2'b10);
                e_ready = (idle && has_g) ? (g ? 2'b10 : 2'b01) : 2'b00;
                e_rsp   = (cyc == rsp_cyc[k]) ? (rsp_idx[k] ? 2'b10 : 2'b01) : 2'b00;
                e_err   = (cyc == rsp_cyc[k]) && rsp_err[k];
                e_wr    = (cyc == wr_cyc[k]) && !rst;
                chk($sformatf("ready[%0d]", k), 32'(o_ready[k]), 32'(e_ready));
                chk($sformatf("rsp_valid[%0d]", k), 32'(o_rsp[k]), 32'(e_rsp));
                chk($sformatf("rsp_err[%0d]", k), 32'(o_err[k]), 32'(e_err));
                chk($sformatf("wr_en[%0d]", k), 32'(o_wr[k]), 32'(e_wr));
                chk($sformatf("busy[%0d]", k), 32'(o_busy[k]), 32'(!idle));
                chk($sformatf("addr[%0d]", k), 32'(o_addr[k]), 32'(m_addr[k]));
                chk($sformatf("data[%0d]", k), o_data[k], m_data[k]);
                if (rst) begin
                    free_at[k] = 0;
                    wr_cyc[k]  = -1;
                    rsp_cyc[k] = -1;
                    m_last[k]  = 1'b1;
                    m_addr[k]  = '0;
                    m_data[k]  = '0;
                end else if (idle && has_g) begin
                    a = g ? a1 : a0;
                    d = g ? d1 : d0;
                    m_last[k]  = g;
                    rsp_idx[k] = g;
                    if (mapped(a)) begin
                        wr_cyc[k]  = cyc + 1;
                        p_addr[k]  = a;
                        p_data[k]  = d;
                        rsp_cyc[k] = cyc + 2;
                        rsp_err[k] = 1'b0;
                        free_at[k] = cyc + 3 + gap_of[k];
                    end else begin
                        rsp_cyc[k] = cyc + 1;
                        rsp_err[k] = 1'b1;
                        free_at[k] = cyc + 2 + gap_of[k];
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        req_valid = 2'b00;
        repeat (n) tick();
    endtask

    // Called just after a clock edge; returns at the negedge of the accepting cycle
    task automatic wait_ready(input int k, input logic [1:0] want);
        int n = 0;
        @(negedge clk);
        while (o_ready[k] !== want && n < 30) begin
            tick();
            @(negedge clk);
            n++;
        end
        chk($sformatf("wait_ready[%0d]", k), 32'(o_ready[k]), 32'(want));
    endtask

    logic [1:0] rd [9];
    logic       wv [9];
    logic [5:0] av [9];

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_wr_en", 32'(o_wr[k]), 32'd0);
            chk("reset_addr", 32'(o_addr[k]), 32'd0);
            chk("reset_busy", 32'(o_busy[k]), 32'd0);
            chk("reset_rsp", 32'(o_rsp[k]), 32'd0);
        end
        tick();
        rst = 1'b0;
        idle_cycles(3);

        // Lone r0 write to 0x05
        req_valid = 2'b01; a0 = 6'h05; d0 = 32'hDEADBEEF;
        @(negedge clk); chk("t1_ready", 32'(o_ready[0]), 32'h1);
        tick(); req_valid = 2'b00;
        @(negedge clk);
        chk("t1_wr_en", 32'(o_wr[0]), 32'h1);
        chk("t1_addr", 32'(o_addr[0]), 32'h05);
        chk("t1_data", o_data[0], 32'hDEADBEEF);
        tick();
        @(negedge clk);
        chk("t1_rsp", 32'(o_rsp[0]), 32'h1);
        chk("t1_err", 32'(o_err[0]), 32'h0);
        idle_cycles(8);

        // r1 to unmapped 0x04: rejected, write channel untouched
        req_valid = 2'b10; a1 = 6'h04; d1 = 32'h12345678;
        @(negedge clk); chk("t3_ready", 32'(o_ready[0]), 32'h2);
        tick(); req_valid = 2'b00;
        @(negedge clk);
        chk("t3_rsp", 32'(o_rsp[0]), 32'h2);
        chk("t3_err", 32'(o_err[0]), 32'h1);
        chk("t3_wr_en", 32'(o_wr[0]), 32'h0);
        chk("t3_addr", 32'(o_addr[0]), 32'h05);
        chk("t3_data", o_data[0], 32'hDEADBEEF);
        idle_cycles(8);

        // Both continuously valid with no gap: grants alternate every 3 cycles
        req_valid = 2'b11; a0 = 6'h08; a1 = 6'h18; d0 = 32'h0808; d1 = 32'h1818;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            rd[i] = o_ready[0]; wv[i] = o_wr[0]; av[i] = o_addr[0];
            if (i < 8) tick();
        end
        chk("t2_grant0", 32'(rd[0]), 32'h1);
        chk("t2_gap_ready", 32'(rd[1]), 32'h0);
        chk("t2_grant1", 32'(rd[3]), 32'h2);
        chk("t2_grant2", 32'(rd[6]), 32'h1);
        chk("t2_wr0", 32'(wv[1]), 32'h1);
        chk("t2_addr0", 32'(av[1]), 32'h08);
        chk("t2_wr_idle", 32'(wv[2]), 32'h0);
        chk("t2_wr1", 32'(wv[4]), 32'h1);
        chk("t2_addr1", 32'(av[4]), 32'h18);
        chk("t2_wr2", 32'(wv[7]), 32'h1);
        chk("t2_addr2", 32'(av[7]), 32'h08);
        tick();
        idle_cycles(10);

        // GAP_CYCLES=3: back-to-back r0 writes, second accepted 6 cycles later
        req_valid = 2'b01; a0 = 6'h00; d0 = 32'hA0;
        wait_ready(1, 2'b01);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) begin a0 = 6'h01; d0 = 32'hA1; end
            @(negedge clk);
            chk("t4_busy", 32'(o_busy[1]), 32'h1);
            chk("t4_no_ready", 32'(o_ready[1]), 32'h0);
        end
        tick();
        @(negedge clk); chk("t4_ready2", 32'(o_ready[1]), 32'h1);
        tick(); req_valid = 2'b00;
        @(negedge clk);
        chk("t4_wr2", 32'(o_wr[1]), 32'h1);
        chk("t4_addr2", 32'(o_addr[1]), 32'h01);
        idle_cycles(10);

        // r0 shows valid only during RESP/GAP of an r1 write: nothing accepted
        req_valid = 2'b10; a1 = 6'h09; d1 = 32'h99;
        @(negedge clk); chk("t6_ready1", 32'(o_ready[1]), 32'h2);
        tick(); req_valid = 2'b00;
        tick(); req_valid = 2'b01; a0 = 6'h0A; d0 = 32'hAA;
        @(negedge clk);
        chk("t6_rsp", 32'(o_rsp[1]), 32'h2);
        chk("t6_no_ready_resp", 32'(o_ready[1]), 32'h0);
        tick();
        @(negedge clk);
        chk("t6_no_ready_gap", 32'(o_ready[1]), 32'h0);
        tick(); req_valid = 2'b00;
        repeat (3) tick();
        req_valid = 2'b11; a0 = 6'h02; a1 = 6'h03;
        @(negedge clk); chk("t6_last_grant", 32'(o_ready[1]), 32'h1);
        tick(); req_valid = 2'b00;
        @(negedge clk);
        chk("t6_wr", 32'(o_wr[1]), 32'h1);
        chk("t6_addr", 32'(o_addr[1]), 32'h02);
        idle_cycles(10);

        // Reset during the WRITE cycle abandons the request
        req_valid = 2'b01; a0 = 6'h0A; d0 = 32'h5A5A;
        wait_ready(0, 2'b01);
        tick(); req_valid = 2'b00; rst = 1'b1;
        @(negedge clk);
        chk("t5_wr_in_reset", 32'(o_wr[0]), 32'h0);
        chk("t5_busy_in_reset", 32'(o_busy[0]), 32'h1);
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("t5_rsp", 32'(o_rsp[0]), 32'h0);
        chk("t5_wr", 32'(o_wr[0]), 32'h0);
        chk("t5_addr", 32'(o_addr[0]), 32'h0);
        chk("t5_data", o_data[0], 32'h0);
        chk("t5_busy", 32'(o_busy[0]), 32'h0);
        tick(); req_valid = 2'b10; a1 = 6'h10; d1 = 32'h77;
        @(negedge clk); chk("t5_ready1", 32'(o_ready[0]), 32'h2);
        tick(); req_valid = 2'b00;
        @(negedge clk);
        chk("t5_wr1", 32'(o_wr[0]), 32'h1);
        chk("t5_addr1", 32'(o_addr[0]), 32'h10);
        idle_cycles(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
